led_sequencer: RTL and testbench
================================

# led_sequencer

Parametrised LED count sequencer with run/pause/single-step control, configurable bounds, and three count modes: bounce, up-wrap and down-wrap. It uses a single value register with a direction flag, and an internal tick prescaler that emits enable pulses rather than a divided clock. It sits between the button debouncers, which supply clean single-cycle pulses, and the LED pins.

## Interface
- `WIDTH`, 4: count and LED width.
- `TICK_DIV`, 2000000: `clk` cycles per count step; must be ≥ 2.
- `clk` input, 1: system clock.
- `rst_btn` input, 1: asynchronous, active-low reset.
- `go` input, 1: one-cycle start pulse.
- `pause` input, 1: one-cycle pulse that toggles RUN/PAUSE.
- `stop` input, 1: one-cycle pulse that returns the block to IDLE.
- `step` input, 1: one-cycle pulse that advances one position while in PAUSE.
- `mode` input, 2: 0 = bounce, 1 = up-wrap, 2 = down-wrap, 3 = treated as 0; sampled on an accepted `go`.
- `lo` input, WIDTH: lower bound; sampled on an accepted `go`.
- `hi` input, WIDTH: upper bound; sampled on an accepted `go`.
- `led` output, WIDTH: current value, registered.
- `running` output, 1: state == RUN.
- `paused` output, 1: state == PAUSE.
- `dir_up` output, 1: current direction.
- `edge_p` output, 1: one-cycle pulse when the value lands on its terminal.

## Operation
- States are IDLE, RUN and PAUSE.
- **Reset:**
  - Reset is asynchronous and takes effect immediately, including mid-operation.
  - Reset values: state = IDLE, `led` = 0, `dir_up` = 1, `edge_p` = 0, prescaler = 0, latched mode/bounds = 0.
- **Command priority** when pulses coincide: `stop` > `pause` > `go` > `step`.
- **IDLE:**
  - `go` latches `mode`, `lo` and `hi`, clears the prescaler, and enters RUN.
  - Start value and direction on `go`:
    - Bounce and up-wrap load `led` = `lo` with `dir_up` = 1.
    - Down-wrap loads `led` = `hi` with `dir_up` = 0.
  - `pause`, `step` and `stop` are ignored.
  - `led` holds its last value while in IDLE.
- **RUN:**
  - The prescaler counts 0..`TICK_DIV`−1; the tick fires when it is at `TICK_DIV`−1.
  - Each tick advances the value one position.
  - `pause` moves to PAUSE; `stop` moves to IDLE; `go` and `step` are ignored.
- **PAUSE:**
  - The prescaler and value are frozen; the prescaler phase is preserved.
  - `pause` returns to RUN, resuming from the preserved phase.
  - `step` advances one position; the prescaler is untouched.
  - `stop` moves to IDLE; `go` is ignored.
- **Advance rule** (H = latched `hi`, L = latched `lo`):
  - Bounce, going up: from H, go to H−1 and clear `dir_up`; otherwise +1.
  - Bounce, going down: from L, go to L+1 and set `dir_up`; otherwise −1. There is no dwell at the endpoints.
  - Up-wrap: H → L, otherwise +1.
  - Down-wrap: L → H, otherwise −1.
- **`edge_p`:** registered alongside `led`. It is 1 for exactly the cycle after an advance that lands on H while `dir_up` = 1, or on L while `dir_up` = 0.
- **Bound boundary cases:**
  - If latched `lo` > `hi`, set H = L = `lo`.
  - If H == L, the value stays constant and every advance pulses `edge_p`.
- **Coincident events:**
  - `pause` or `stop` in the same cycle as a tick wins; no advance occurs.
  - `pause` arriving in the same cycle as an accepted `step` is handled by priority, so the `step` is dropped.
- All arithmetic is modulo 2^WIDTH. Bounds make overflow unreachable except through the explicit wrap rules.

## Timing
- `go` is accepted at edge N: `running`, `led` = start value and `dir_up` are valid after edge N.
- First advance occurs at edge N+`TICK_DIV`; later advances follow every `TICK_DIV` cycles.
- `step` at edge N gives the new `led` after edge N; `edge_p` asserts in the same cycle as that value.
- `pause`/`stop` take effect at their edge. The state output updates after that edge.
- Outputs are fully registered; there are no combinational paths from input to output.

## Structure
- Package `led_seq_pkg` holds:
  - the state encoding (IDLE/RUN/PAUSE);
  - the mode constants: MODE_BOUNCE, MODE_UP_WRAP, MODE_DOWN_WRAP.
- Sub-module `tick_prescaler`:
  - parameter `TICK_DIV`;
  - inputs `clk`, `rst_btn`, `en`, `clr`;
  - output `tick`, a one-cycle pulse;
  - counter width is $clog2(`TICK_DIV`).
- The top level contains the FSM, the value/direction registers, and the advance logic.

## Test plan
All scenarios use `TICK_DIV` = 4 and `WIDTH` = 4.

1. **Bounce:** `lo`=2, `hi`=5, `go` → `led` sequence 2,3,4,5,4,3,2,3, one step every 4 cycles. `edge_p` pulses at 5 and at 2. `dir_up` flips on leaving 5.
2. **Up-wrap then down-wrap:**
   - Up-wrap, `lo`=0, `hi`=15: `led` 14,15,0,1; `edge_p` pulses with 15.
   - Down-wrap, `lo`=3, `hi`=6: `led` 6,5,4,3,6; `edge_p` pulses with 3.
3. **Pause/step:** pause 1 cycle after a tick, so `led` holds for 20 cycles. Two `step` pulses advance it 2 positions. Resume → next tick after exactly 3 cycles (phase preserved).
4. **Priority:**
   - `pause`+`stop` in the same cycle → IDLE, `led` held.
   - `go` during RUN → ignored.
   - `pause` coinciding with a tick → no advance.
5. **Degenerate bounds:**
   - `lo`=`hi`=7 → `led` stays 7, `edge_p` every 4 cycles.
   - `lo`=9, `hi`=3 → `led` stays 9.
6. **Async reset:** `rst_btn` low mid-RUN, between edges → `led`=0 and `running`=0 immediately. After release, no activity until `go`.

Source files
------------

// File: rtl/led_seq_pkg.sv
// ============================================================================
// Module   : led_seq_pkg
// Brief    : Shared state and count-mode encodings for the LED sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BOUNCE    = 2'd0;
  localparam logic [1:0] MODE_UP_WRAP   = 2'd1;
  localparam logic [1:0] MODE_DOWN_WRAP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/led_sequencer_if.sv
// ============================================================================
// Module   : led_sequencer_if
// Brief    : Command pulses, configuration and status bundle of the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface led_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             go;
  logic             pause;
  logic             stop;
  logic             step;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] led;
  logic             running;
  logic             paused;
  logic             dir_up;
  logic             edge_p;

  modport master (
    output go, pause, stop, step, mode, lo, hi,
    input  led, running, paused, dir_up, edge_p
  );

  modport slave (
    input  go, pause, stop, step, mode, lo, hi,
    output led, running, paused, dir_up, edge_p
  );
endinterface

`default_nettype wire

// File: rtl/led_sequencer_tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Brief    : Free-running modulo-TICK_DIV counter emitting a one-cycle enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int TICK_DIV = 2000000
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int              CW     = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   c_last = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Holding the count while disabled preserves the phase across a pause.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/led_sequencer.sv
// ============================================================================
// Module   : led_sequencer
// Brief    : Run/pause/step LED counter with bounce, up-wrap and down-wrap modes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 2000000
) (
  input  logic           clk,
  input  logic           rst_btn,
  led_sequencer_if.slave bus
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_go_acc;
  logic             w_adv;
  logic             w_tick;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_led;
  logic             r_dir;
  logic             r_edge;
  logic [WIDTH-1:0] w_h;
  logic [WIDTH-1:0] w_l;
  logic [WIDTH-1:0] w_go_h;
  logic [WIDTH-1:0] w_adv_led;
  logic             w_adv_dir;
  logic             w_adv_edge;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst_btn (rst_btn),
    .en      (r_state == ST_RUN),
    .clr     (w_go_acc),
    .tick    (w_tick)
  );

  // Inverted bounds collapse onto lo.
  assign w_l    = r_lo;
  assign w_h    = (r_lo > r_hi) ? r_lo : r_hi;
  assign w_go_h = (bus.lo > bus.hi) ? bus.lo : bus.hi;

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go_acc    = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.go && !bus.stop && !bus.pause) begin
          w_go_acc    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.pause) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_tick) begin
          w_adv = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.pause) begin
          w_state_nxt = ST_RUN;
        end else if (bus.step) begin
          w_adv = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_adv_led = r_led;
    w_adv_dir = r_dir;
    case (r_mode)
      MODE_UP_WRAP: begin
        w_adv_dir = 1'b1;
        w_adv_led = (r_led == w_h) ? w_l : r_led + 1'b1;
      end
      MODE_DOWN_WRAP: begin
        w_adv_dir = 1'b0;
        w_adv_led = (r_led == w_l) ? w_h : r_led - 1'b1;
      end
      default: begin
        // Bounce reverses on the endpoint itself, so there is no dwell.
        if (w_h == w_l) begin
          w_adv_led = w_l;
        end else if (r_dir) begin
          if (r_led == w_h) begin
            w_adv_led = w_h - 1'b1;
            w_adv_dir = 1'b0;
          end else begin
            w_adv_led = r_led + 1'b1;
          end
        end else begin
          if (r_led == w_l) begin
            w_adv_led = w_l + 1'b1;
            w_adv_dir = 1'b1;
          end else begin
            w_adv_led = r_led - 1'b1;
          end
        end
      end
    endcase
    w_adv_edge = (w_adv_dir && (w_adv_led == w_h)) ||
                 (!w_adv_dir && (w_adv_led == w_l));
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      r_mode <= MODE_BOUNCE;
      r_lo   <= '0;
      r_hi   <= '0;
      r_led  <= '0;
      r_dir  <= 1'b1;
      r_edge <= 1'b0;
    end else begin
      r_edge <= 1'b0;
      if (w_go_acc) begin
        r_mode <= bus.mode;
        r_lo   <= bus.lo;
        r_hi   <= bus.hi;
        if (bus.mode == MODE_DOWN_WRAP) begin
          r_led <= w_go_h;
          r_dir <= 1'b0;
        end else begin
          r_led <= bus.lo;
          r_dir <= 1'b1;
        end
      end else if (w_adv) begin
        r_led  <= w_adv_led;
        r_dir  <= w_adv_dir;
        r_edge <= w_adv_edge;
      end
    end
  end

  assign bus.led     = r_led;
  assign bus.dir_up  = r_dir;
  assign bus.edge_p  = r_edge;
  assign bus.running = (r_state == ST_RUN);
  assign bus.paused  = (r_state == ST_PAUSE);

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// ============================================================================
// Module   : tb_led_sequencer
// Brief    : Directed scoreboard bench for led_sequencer (WIDTH 4, TICK_DIV 4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_sequencer;
  localparam int WIDTH    = 4;
  localparam int TICK_DIV = 4;

  logic clk     = 1'b0;
  logic rst_btn = 1'b0;

  led_sequencer_if #(.WIDTH(WIDTH)) bus ();

  led_sequencer #(
    .WIDTH    (WIDTH),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk     (clk),
    .rst_btn (rst_btn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] led;
    logic       dir;
    logic       edg;
    logic       run;
    logic       pau;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic expect_st(input logic [3:0] led, input logic dir, input logic edg,
                           input logic run, input logic pau);
    exp_t e;
    e.led = led;
    e.dir = dir;
    e.edg = edg;
    e.run = run;
    e.pau = pau;
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    exp_t obs;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_errors++;
      $error("FAIL %s: scoreboard empty, observed led=%0d", tag, bus.led);
    end
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = {bus.led, bus.dir_up, bus.edge_p, bus.running, bus.paused};
      assert (obs === e) else begin
        n_errors++;
        $error("FAIL %s: observed led=%0d dir=%b edge=%b run=%b pause=%b, expected led=%0d dir=%b edge=%b run=%b pause=%b",
               tag, obs.led, obs.dir, obs.edg, obs.run, obs.pau, e.led, e.dir, e.edg, e.run, e.pau);
      end
    end
  endtask

  // Drives the given pulses for exactly one active edge, starting at a negedge.
  task automatic pulse(input logic g, input logic p, input logic s, input logic st);
    bus.go    = g;
    bus.pause = p;
    bus.stop  = s;
    bus.step  = st;
    @(negedge clk);
    bus.go    = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    bus.step  = 1'b0;
  endtask

  task automatic start(input logic [1:0] mode, input logic [3:0] lo, input logic [3:0] hi,
                       input logic [3:0] led, input logic dir, input string tag);
    bus.mode = mode;
    bus.lo   = lo;
    bus.hi   = hi;
    expect_st(led, dir, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check(tag);
  endtask

  task automatic tick_check(input logic [3:0] led, input logic dir, input logic edg,
                            input string tag);
    expect_st(led, dir, edg, 1'b1, 1'b0);
    repeat (TICK_DIV) @(negedge clk);
    check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] v;
    bus.go = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0; bus.step = 1'b0;
    bus.mode = 2'd0; bus.lo = '0; bus.hi = '0;
    repeat (3) @(negedge clk);
    expect_st(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset");
    rst_btn = 1'b1;
    @(negedge clk);

    // Bounce 2..5
    start(2'd0, 4'd2, 4'd5, 4'd2, 1'b1, "bounce_go");
    tick_check(4'd3, 1'b1, 1'b0, "bounce_3");
    tick_check(4'd4, 1'b1, 1'b0, "bounce_4");
    tick_check(4'd5, 1'b1, 1'b1, "bounce_5");
    tick_check(4'd4, 1'b0, 1'b0, "bounce_4d");
    tick_check(4'd3, 1'b0, 1'b0, "bounce_3d");
    tick_check(4'd2, 1'b0, 1'b1, "bounce_2d");
    tick_check(4'd3, 1'b1, 1'b0, "bounce_3u");
    expect_st(4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("stop_hold");

    // Up-wrap over the full range
    start(2'd1, 4'd0, 4'd15, 4'd0, 1'b1, "upwrap_go");
    for (int i = 1; i <= 17; i++) begin
      v = 4'(i);
      tick_check(v, 1'b1, (v == 4'd15), "upwrap");
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);

    // Down-wrap 6..3
    start(2'd2, 4'd3, 4'd6, 4'd6, 1'b0, "downwrap_go");
    tick_check(4'd5, 1'b0, 1'b0, "downwrap_5");
    tick_check(4'd4, 1'b0, 1'b0, "downwrap_4");
    tick_check(4'd3, 1'b0, 1'b1, "downwrap_3");
    tick_check(4'd6, 1'b0, 1'b0, "downwrap_6");
    pulse(1'b0, 1'b0, 1'b1, 1'b0);

    // Pause one cycle after a tick, step twice, resume with preserved phase
    start(2'd1, 4'd0, 4'd15, 4'd0, 1'b1, "pause_go");
    tick_check(4'd1, 1'b1, 1'b0, "pause_tick");
    expect_st(4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("pause_enter");
    expect_st(4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("pause_hold");
    expect_st(4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("step_1");
    expect_st(4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("step_2");
    expect_st(4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("resume");
    expect_st(4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("resume_hold");
    expect_st(4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("resume_tick3");

    // go during RUN is ignored
    bus.mode = 2'd2; bus.lo = 4'd9; bus.hi = 4'd12;
    expect_st(4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("go_in_run");
    // pause on the tick cycle wins over the advance
    repeat (2) @(negedge clk);
    expect_st(4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("pause_on_tick");
    // pause + stop together: stop wins
    expect_st(4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("pause_stop");

    // Degenerate bounds
    start(2'd0, 4'd7, 4'd7, 4'd7, 1'b1, "eq_go");
    tick_check(4'd7, 1'b1, 1'b1, "eq_tick1");
    expect_st(4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("eq_edge_clear");
    expect_st(4'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (TICK_DIV - 1) @(negedge clk);
    check("eq_tick2");
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    start(2'd0, 4'd9, 4'd3, 4'd9, 1'b1, "inv_go");
    tick_check(4'd9, 1'b1, 1'b1, "inv_tick1");
    tick_check(4'd9, 1'b1, 1'b1, "inv_tick2");
    pulse(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges
    start(2'd0, 4'd2, 4'd5, 4'd2, 1'b1, "rst_go");
    tick_check(4'd3, 1'b1, 1'b0, "rst_tick");
    #2 rst_btn = 1'b0;
    #1;
    expect_st(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("async_rst");
    @(negedge clk);
    rst_btn = 1'b1;
    expect_st(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("post_rst_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
